// File: rtl/seq_divider.sv
// Iterative restoring divider producing one quotient bit per clock, WIDTH+2 cycles per operation.
// Optional two's-complement mode is enabled by defining SEQ_DIV_SIGNED_EN.
module seq_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remd_q, remd_d;
    logic             dbz_q, dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
`endif

    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic             unused_diff_msb;

    // Shifted partial remainder is below 2*divisor, so a WIDTH+1 bit compare decides the bit.
    assign r_sh            = {rem_q, acc_q[WIDTH-1]};
    assign diff            = r_sh - {1'b0, dvs_q};
    assign ge              = (r_sh >= {1'b0, dvs_q});
    assign r_next          = ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
    assign q_next          = {acc_q[WIDTH-2:0], ge};
    assign unused_diff_msb = diff[WIDTH];

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        remd_d  = remd_q;
        dbz_d   = dbz_q;
`ifdef SEQ_DIV_SIGNED_EN
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (divisor == '0) begin
                        quot_d  = '1;
                        remd_d  = dividend;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        rem_d   = '0;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = StCalc;
`ifdef SEQ_DIV_SIGNED_EN
                        acc_d      = dividend[WIDTH-1] ? -dividend : dividend;
                        dvs_d      = divisor[WIDTH-1] ? -divisor : divisor;
                        neg_quot_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_rem_d  = dividend[WIDTH-1];
`else
                        acc_d = dividend;
                        dvs_d = divisor;
`endif
                    end
                end
            end
            StCalc: begin
                rem_d = r_next;
                acc_d = q_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastStep) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = StDone;
`ifdef SEQ_DIV_SIGNED_EN
                    quot_d = neg_quot_q ? -q_next : q_next;
                    remd_d = neg_rem_q ? -r_next : r_next;
`else
                    quot_d = q_next;
                    remd_d = r_next;
`endif
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rem_q   <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            remd_q  <= '0;
            dbz_q   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            remd_q  <= remd_d;
            dbz_q   <= dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = remd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver pushes reference results, monitor pops on done.
// Signed cases are added when SEQ_DIV_SIGNED_EN is defined.
module tb_seq_divider;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division; done appears in the cycle after the accept edge
    // for divide-by-zero, otherwise W cycles later.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
        exp_t e;
        e.dbz = (b == '0);
        e.cyc = (b == '0) ? k : k + W;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
        end else begin
`ifdef SEQ_DIV_SIGNED_EN
            int sa;
            int sd;
            sa  = int'($signed(a));
            sd  = int'($signed(b));
            e.q = W'(sa / sd);
            e.r = W'(sa % sd);
`else
            e.q = a / b;
            e.r = a % b;
`endif
        end
        return e;
    endfunction

    // Monitor: every done must match the oldest outstanding request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 with no request outstanding (cycle %0d)",
                             cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("div_by_zero", div_by_zero, e.dbz);
                    chk("done_cycle", cyc, e.cyc);
                    chk("busy_in_done", busy, 1'b1);
                end
            end
        end
    end

    // Called at a negedge; returns at the first negedge with busy low.
    task automatic wait_idle(output int c);
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy still high after 100 cycles, expected 0");
        end
        c = cyc;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, output exp_t e);
        int c;
        wait_idle(c);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        e = model(a, b, cyc + 1);
        exp_q.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        chk("busy_after_start", busy, 1'b1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        exp_t e;
        int   c;
        issue(a, b, e);
        wait_idle(c);
        chk("busy_fall_cycle", c, e.cyc + 1);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            chk("held_quotient", quotient, e.q);
            chk("held_remainder", remainder, e.r);
            chk("held_div_by_zero", div_by_zero, e.dbz);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   c;
        int   k;
        logic [W-1:0] a;
        logic [W-1:0] b;

        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_quotient", quotient, '0);
        chk("reset_remainder", remainder, '0);
        chk("reset_div_by_zero", div_by_zero, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'd100, 8'd7, 2);
        run_op(8'd255, 8'd1, 20);
        run_op(8'd3, 8'd200, 20);
        run_op(8'h80, 8'h80, 20);
        run_op(8'd5, 8'd0, 3);
        run_op(8'd9, 8'd3, 3);

        // Extra start pulses during CALC and in the DONE cycle must be dropped.
        issue(8'd50, 8'd5, e);
        k = e.cyc - W;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; dividend = 8'd77; divisor = 8'd3;
        @(negedge clk);
        start = 1'b0;
        while (cyc < k + W) @(negedge clk);
        start = 1'b1; dividend = 8'd1; divisor = 8'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (W + 4) @(negedge clk);
        chk("ignored_start_busy", busy, 1'b0);
        chk("ignored_start_quotient", quotient, 8'd10);
        chk("ignored_start_remainder", remainder, 8'd0);

        // Reset in the middle of an operation aborts it without a done.
        wait_idle(c);
        start = 1'b1; dividend = 8'd200; divisor = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_quotient", quotient, '0);
        chk("abort_remainder", remainder, '0);
        chk("abort_div_by_zero", div_by_zero, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 4) @(negedge clk);
        chk("abort_no_restart", busy, 1'b0);
        run_op(8'd77, 8'd8, 2);

`ifdef SEQ_DIV_SIGNED_EN
        run_op(8'h9C, 8'd7, 2);
        run_op(8'd100, 8'hF9, 2);
        run_op(8'h80, 8'hFF, 2);
        run_op(8'h80, 8'h01, 2);
        run_op(8'hF9, 8'h00, 2);
`endif

        for (int i = 0; i < 60; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2, 3: b = W'($urandom_range(1, 15));
                default: b = W'($urandom);
            endcase
            run_op(a, b, (i % 8 == 0) ? 3 : 0);
        end

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
